// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, clocks out one byte
// with odd parity under device clocking, and checks the device ack.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clock_in,
  input  logic       ps2_data_in,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  clk_sync_q, dat_sync_q;
  logic        clk_prev_q;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  sh_q, sh_d;
  logic        clk_oe_q, clk_oe_d;
  logic        dat_oe_q, dat_oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  ec_q, ec_d;
  logic        clk_s, dat_s, fall;
  logic        abort;
  logic [1:0]  abort_code;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 20'd1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ec_d       = ec_q;
    abort      = 1'b0;
    abort_code = 2'b00;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (send) begin
          sh_d     = {1'b1, ~^tx_data, tx_data};
          ec_d     = 2'b00;
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          state_d  = RELEASE;
        end
      end
      RELEASE, SHIFT: begin
        if (fall) begin
          cnt_d    = '0;
          dat_oe_d = ~sh_q[0];
          sh_d     = {1'b1, sh_q[9:1]};
          if (state_q == RELEASE) begin
            bit_d   = 4'd1;
            state_d = SHIFT;
          end else begin
            bit_d = bit_q + 4'd1;
            // bit_q==9 means this edge presents the stop bit
            if (bit_q == 4'd9) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!dat_s) begin
            state_d = WAIT_IDLE;
          end else begin
            abort      = 1'b1;
            abort_code = 2'b10;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!abort && !done_d && !fall && cnt_q == TO_LAST &&
        state_q != IDLE && state_q != INHIBIT) begin
      abort      = 1'b1;
      abort_code = 2'b01;
    end

    if (abort) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = 1'b0;
      err_d    = 1'b1;
      ec_d     = abort_code;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ec_q       <= 2'b00;
    end else begin
      state_q    <= state_d;
      clk_sync_q <= {clk_sync_q[0], ps2_clock_in};
      dat_sync_q <= {dat_sync_q[0], ps2_data_in};
      clk_prev_q <= clk_s;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      clk_oe_q   <= clk_oe_d;
      dat_oe_q   <= dat_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ec_q       <= ec_d;
    end
  end

  assign ps2_clock_oe = clk_oe_q;
  assign ps2_data_oe  = dat_oe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign err_code     = ec_q;

endmodule
